// File: rtl/sentinel_pkg.sv
// Shared types and constants for the Sentinel lock: controller state encoding,
// default key and the display segment codes the display driver also uses.
package sentinel_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } sentinel_state_t;

    localparam logic [7:0] KEY_DEFAULT  = 8'hB6;
    localparam logic [7:0] SEG_LOCKED   = 8'hC7;
    localparam logic [7:0] SEG_VERIFIED = 8'hC1;
    localparam logic [7:0] SEG_OFF      = 8'hFF;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sentinel_timer.sv
// Loadable down-counter with terminal-count flag; shared by the unlock window
// and the lockout period.
module sentinel_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sentinel_auth_ctrl.sv
// Authorization sequencer: meters key attempts, opens a timed unlock window on
// a match and imposes a timed lockout after MAX_FAILS consecutive misses.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_LOCKED   | idle, waiting for a key strobe
// ST_CHECK    | one cycle comparing the latched key against KEY
// ST_UNLOCKED | unlock window running; strobes re-evaluated in place
// ST_LOCKOUT  | too many failures; strobes ignored until the timer expires
module sentinel_auth_ctrl
    import sentinel_pkg::*;
#(
    parameter logic [7:0]  KEY            = KEY_DEFAULT,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned UNLOCK_CYCLES  = 1_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 10_000_000,
    localparam int unsigned FCW           = $clog2(MAX_FAILS + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena_i,
    input  logic [7:0]     key_in_i,
    input  logic           key_strobe_i,
    output logic           unlocked_o,
    output logic           lockout_o,
    output logic [FCW-1:0] fail_count_o,
    output logic           attempt_done_o,
    output logic           attempt_ok_o,
    output logic [1:0]     state_o
);

    localparam int unsigned TMR_MAX = max_u(UNLOCK_CYCLES, LOCKOUT_CYCLES);
    localparam int unsigned TW      = ($clog2(TMR_MAX) < 1) ? 1 : $clog2(TMR_MAX);

    localparam logic [TW-1:0]  UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0]  LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FCW-1:0] FAIL_LAST    = FCW'(MAX_FAILS - 1);
    localparam logic [FCW-1:0] FAIL_SAT     = FCW'(MAX_FAILS);

    sentinel_state_t state_q, state_d;
    logic [FCW-1:0]  fail_count_q, fail_count_d;
    logic [7:0]      key_latch_q, key_latch_d;
    logic            attempt_done_q, attempt_done_d;
    logic            attempt_ok_q, attempt_ok_d;
    logic            unlocked_q, unlocked_d;
    logic            lockout_q, lockout_d;

    logic            tmr_load;
    logic [TW-1:0]   tmr_load_val;
    logic            tmr_en;
    logic            tmr_zero;

    sentinel_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_LOCKED;
            fail_count_q   <= '0;
            key_latch_q    <= '0;
            attempt_done_q <= 1'b0;
            attempt_ok_q   <= 1'b0;
            unlocked_q     <= 1'b0;
            lockout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            fail_count_q   <= fail_count_d;
            key_latch_q    <= key_latch_d;
            attempt_done_q <= attempt_done_d;
            attempt_ok_q   <= attempt_ok_d;
            unlocked_q     <= unlocked_d;
            lockout_q      <= lockout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        fail_count_d   = fail_count_q;
        key_latch_d    = key_latch_q;
        attempt_done_d = 1'b0;
        attempt_ok_d   = attempt_ok_q;
        tmr_load       = 1'b0;
        tmr_load_val   = UNLOCK_LOAD;
        tmr_en         = 1'b0;

        // With ena low everything holds, including the timer and any lockout.
        if (ena_i) begin
            case (state_q)
                ST_LOCKED: begin
                    if (key_strobe_i) begin
                        key_latch_d = key_in_i;
                        state_d     = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    attempt_done_d = 1'b1;
                    attempt_ok_d   = (key_latch_q == KEY);
                    if (key_latch_q == KEY) begin
                        fail_count_d = '0;
                        tmr_load     = 1'b1;
                        tmr_load_val = UNLOCK_LOAD;
                        state_d      = ST_UNLOCKED;
                    end else if (fail_count_q < FAIL_LAST) begin
                        fail_count_d = fail_count_q + FCW'(1);
                        state_d      = ST_LOCKED;
                    end else begin
                        fail_count_d = FAIL_SAT;
                        tmr_load     = 1'b1;
                        tmr_load_val = LOCKOUT_LOAD;
                        state_d      = ST_LOCKOUT;
                    end
                end
                ST_UNLOCKED: begin
                    // A strobe takes priority over window expiry in the same cycle.
                    if (key_strobe_i) begin
                        key_latch_d    = key_in_i;
                        attempt_done_d = 1'b1;
                        attempt_ok_d   = (key_in_i == KEY);
                        if (key_in_i == KEY) begin
                            tmr_load     = 1'b1;
                            tmr_load_val = UNLOCK_LOAD;
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end else if (tmr_zero) begin
                        state_d = ST_LOCKED;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (tmr_zero) begin
                        fail_count_d = '0;
                        state_d      = ST_LOCKED;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
            endcase
        end

        unlocked_d = ena_i && (state_d == ST_UNLOCKED);
        lockout_d  = (state_d == ST_LOCKOUT);
    end

    assign unlocked_o     = unlocked_q;
    assign lockout_o      = lockout_q;
    assign fail_count_o   = fail_count_q;
    assign attempt_done_o = attempt_done_q;
    assign attempt_ok_o   = attempt_ok_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_sentinel_auth_ctrl.sv
// Directed bench for sentinel_auth_ctrl with a queue scoreboard for attempt results.
module tb_sentinel_auth_ctrl;

    localparam int unsigned MAX_FAILS = 3;
    localparam int unsigned UNLOCK_C  = 8;
    localparam int unsigned LOCKOUT_C = 16;
    localparam int unsigned FCW       = $clog2(MAX_FAILS + 1);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ena;
    logic [7:0]     key_in;
    logic           key_strobe;
    logic           unlocked_o;
    logic           lockout_o;
    logic [FCW-1:0] fail_count_o;
    logic           attempt_done_o;
    logic           attempt_ok_o;
    logic [1:0]     state_o;

    int checks   = 0;
    int failures = 0;
    bit exp_q[$];

    sentinel_auth_ctrl #(
        .KEY            (8'hB6),
        .MAX_FAILS      (MAX_FAILS),
        .UNLOCK_CYCLES  (UNLOCK_C),
        .LOCKOUT_CYCLES (LOCKOUT_C)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena_i          (ena),
        .key_in_i       (key_in),
        .key_strobe_i   (key_strobe),
        .unlocked_o     (unlocked_o),
        .lockout_o      (lockout_o),
        .fail_count_o   (fail_count_o),
        .attempt_done_o (attempt_done_o),
        .attempt_ok_o   (attempt_ok_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every attempt_done must match a queued expectation, in order.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && attempt_done_o === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_attempt_done", 32'd1, 32'd0);
            else check("attempt_ok", 32'(attempt_ok_o), 32'(exp_q.pop_front()));
        end
    end

    task automatic send_key(input logic [7:0] k, input bit evaluated, input bit exp_ok);
        key_in     = k;
        key_strobe = 1'b1;
        if (evaluated) exp_q.push_back(exp_ok);
        @(negedge clk);
        key_strobe = 1'b0;
    endtask

    // Counts consecutive cycles the selected output stays high, starting now;
    // optionally pulses a strobe at cycle index strobe_at of that run.
    task automatic count_high(input bit sel_lock, input int strobe_at,
                              input logic [7:0] skey, output int n);
        n = 0;
        while (((sel_lock ? lockout_o : unlocked_o) === 1'b1) && n < 100) begin
            key_in     = skey;
            key_strobe = (n == strobe_at);
            n++;
            @(negedge clk);
        end
        key_strobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; ena = 1'b1; key_in = 8'h00; key_strobe = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state",    32'(state_o),        32'd0);
        check("rst_unlocked", 32'(unlocked_o),     32'd0);
        check("rst_lockout",  32'(lockout_o),      32'd0);
        check("rst_fails",    32'(fail_count_o),   32'd0);
        check("rst_done",     32'(attempt_done_o), 32'd0);
        check("rst_ok",       32'(attempt_ok_o),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct key: CHECK for one cycle, then an 8-cycle window.
        send_key(8'hB6, 1'b1, 1'b1);
        check("t1_check_state", 32'(state_o), 32'd1);
        check("t1_unlock_early", 32'(unlocked_o), 32'd0);
        @(negedge clk);
        check("t1_state_unl", 32'(state_o), 32'd2);
        check("t1_done", 32'(attempt_done_o), 32'd1);
        count_high(1'b0, -1, 8'h00, n);
        check("t1_window_len", 32'(n), UNLOCK_C);
        check("t1_state_after", 32'(state_o), 32'd0);
        check("t1_ok_held", 32'(attempt_ok_o), 32'd1);

        // Three misses lead to lockout; a correct key during lockout is ignored.
        send_key(8'h00, 1'b1, 1'b0); @(negedge clk);
        check("t2_fail1", 32'(fail_count_o), 32'd1);
        send_key(8'h11, 1'b1, 1'b0); @(negedge clk);
        check("t2_fail2", 32'(fail_count_o), 32'd2);
        check("t2_no_lock_yet", 32'(lockout_o), 32'd0);
        send_key(8'h22, 1'b1, 1'b0);
        check("t2_lock_not_yet", 32'(lockout_o), 32'd0);
        @(negedge clk);
        check("t2_lockout", 32'(lockout_o), 32'd1);
        check("t2_fail3", 32'(fail_count_o), 32'd3);
        check("t2_state_lo", 32'(state_o), 32'd3);
        count_high(1'b1, 3, 8'hB6, n);
        check("t2_lockout_len", 32'(n), LOCKOUT_C);
        check("t2_fail_clear", 32'(fail_count_o), 32'd0);
        check("t2_state_after", 32'(state_o), 32'd0);

        // A match clears the failure count; two later misses stay below lockout.
        send_key(8'h00, 1'b1, 1'b0); @(negedge clk);
        check("t3_fail1", 32'(fail_count_o), 32'd1);
        send_key(8'hB6, 1'b1, 1'b1); @(negedge clk);
        check("t3_fail_zero", 32'(fail_count_o), 32'd0);
        check("t3_unlocked", 32'(unlocked_o), 32'd1);
        count_high(1'b0, -1, 8'h00, n);
        check("t3_window_len", 32'(n), UNLOCK_C);
        send_key(8'h00, 1'b1, 1'b0); @(negedge clk);
        send_key(8'h11, 1'b1, 1'b0); @(negedge clk);
        check("t3_fail2", 32'(fail_count_o), 32'd2);
        check("t3_no_lockout", 32'(lockout_o), 32'd0);
        check("t3_state", 32'(state_o), 32'd0);

        // Re-evaluation at window cycle 6 extends by a full window: 6 + 8.
        send_key(8'hB6, 1'b1, 1'b1); @(negedge clk);
        check("t4_unlocked", 32'(unlocked_o), 32'd1);
        exp_q.push_back(1'b1);
        count_high(1'b0, 5, 8'hB6, n);
        check("t4_extended_len", 32'(n), 6 + UNLOCK_C);
        send_key(8'hB6, 1'b1, 1'b1); @(negedge clk);
        check("t4_unlocked2", 32'(unlocked_o), 32'd1);
        send_key(8'h5A, 1'b1, 1'b0);
        check("t4_bad_state", 32'(state_o), 32'd0);
        check("t4_bad_unlocked", 32'(unlocked_o), 32'd0);
        check("t4_bad_done", 32'(attempt_done_o), 32'd1);
        check("t4_bad_fails", 32'(fail_count_o), 32'd0);

        // Strobes are ignored while disabled.
        ena = 1'b0;
        send_key(8'hB6, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_dis_state", 32'(state_o), 32'd0);
        ena = 1'b1;

        // Freeze mid-lockout: 4 cycles (timer 15..12), hold 20, resume from 12.
        send_key(8'h01, 1'b1, 1'b0); @(negedge clk);
        send_key(8'h02, 1'b1, 1'b0); @(negedge clk);
        send_key(8'h03, 1'b1, 1'b0); @(negedge clk);
        check("t5_lockout", 32'(lockout_o), 32'd1);
        repeat (3) @(negedge clk);
        ena = 1'b0;
        for (int i = 0; i < 20; i++) begin
            key_in = 8'hB6; key_strobe = (i == 7);
            @(negedge clk);
            if (i % 5 == 4) begin
                check("t5_frozen_lockout", 32'(lockout_o), 32'd1);
                check("t5_frozen_state", 32'(state_o), 32'd3);
                check("t5_frozen_fails", 32'(fail_count_o), 32'd3);
            end
        end
        key_strobe = 1'b0;
        ena = 1'b1;
        count_high(1'b1, -1, 8'h00, n);
        check("t5_resume_len", 32'(n), LOCKOUT_C - 4 + 1);
        check("t5_fail_clear", 32'(fail_count_o), 32'd0);

        // Dropping ena forces unlocked low; reset mid-window clears without a clock edge.
        send_key(8'hB6, 1'b1, 1'b1); @(negedge clk);
        check("t6_unlocked", 32'(unlocked_o), 32'd1);
        ena = 1'b0;
        @(negedge clk);
        check("t6_ena_off_unl", 32'(unlocked_o), 32'd0);
        check("t6_ena_off_state", 32'(state_o), 32'd2);
        ena = 1'b1;
        @(negedge clk);
        check("t6_ena_on_unl", 32'(unlocked_o), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_state",    32'(state_o),        32'd0);
        check("t6_rst_unlocked", 32'(unlocked_o),     32'd0);
        check("t6_rst_lockout",  32'(lockout_o),      32'd0);
        check("t6_rst_fails",    32'(fail_count_o),   32'd0);
        check("t6_rst_done",     32'(attempt_done_o), 32'd0);
        check("t6_rst_ok",       32'(attempt_ok_o),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_post_state", 32'(state_o), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sentinel_auth_ctrl.md
# sentinel_auth_ctrl

Sequencing controller for the Citadel Sentinel lock. It turns the debounced key bus into a metered authorization process: every presented key is one attempt, and a match opens a timed unlock window. Consecutive failures lead to a timed lockout during which keys are ignored. The controller sits between the input sanitizer and the display/status-array drivers, replacing their direct combinational key compare.

## Interface
Parameters:
- KEY, 8'hB6: authorization key.
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout; must be ≥1.
- UNLOCK_CYCLES, 1_000_000: unlock window length in cycles; must be ≥1.
- LOCKOUT_CYCLES, 10_000_000: lockout length in cycles; must be ≥1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  power-state enable.
- key_in  in  8  debounced key bus, synchronous to clk.
- key_strobe  in  1  one-cycle pulse marking a newly stable key_in value (one attempt).
- unlocked  out  1  registered; high during the unlock window while ena=1.
- lockout  out  1  registered; high during lockout.
- fail_count  out  $clog2(MAX_FAILS+1)  registered count of consecutive failures.
- attempt_done  out  1  one-cycle pulse when an attempt is evaluated.
- attempt_ok  out  1  result of the last evaluated attempt; valid from attempt_done onward.
- state  out  2  current FSM state encoding.

## Operation
- States: LOCKED=0, CHECK=1, UNLOCKED=2, LOCKOUT=3.
- Reset: state=LOCKED. The timer, fail_count, unlocked, lockout, attempt_done, attempt_ok and the key latch are all 0.
- LOCKED:
  - On key_strobe with ena=1: latch key_in and go to CHECK.
- CHECK (exactly one cycle): compare the latch to KEY. Pulse attempt_done and set attempt_ok to the compare result.
  - Match: go to UNLOCKED, clear fail_count, load timer=UNLOCK_CYCLES-1.
  - Mismatch with fail_count+1 < MAX_FAILS: increment fail_count, go to LOCKED.
  - Mismatch with fail_count+1 == MAX_FAILS: set fail_count=MAX_FAILS (saturated), load timer=LOCKOUT_CYCLES-1, go to LOCKOUT.
- UNLOCKED: the timer decrements each cycle. When timer==0, go to LOCKED.
  - A key_strobe in this state is latched and re-evaluated combinationally in the same cycle. It does not pass through CHECK.
  - Match: reload the timer and pulse attempt_done with attempt_ok=1.
  - Mismatch: go to LOCKED immediately and pulse attempt_done with attempt_ok=0. fail_count is NOT incremented.
  - Strobe and expiry in the same cycle: the strobe wins.
- LOCKOUT: key_strobe is ignored (no latch, no attempt_done). The timer decrements each cycle. When timer==0, go to LOCKED and clear fail_count.
- A key_strobe arriving while in CHECK is dropped.
- ena=0:
  - FSM, timer and fail_count freeze.
  - Strobes are ignored.
  - The unlocked output is forced to 0; lockout and fail_count still reflect the frozen state.
  - Dropping ena does not clear a lockout.
- Reset asserted mid-window or mid-lockout returns all state to reset values on the asynchronous edge.
- Timer width is $clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)). Decrement never wraps, because the state leaves on 0.

## Timing
- Strobe at edge N → CHECK during cycle N+1 → unlocked or lockout rises, and attempt_done pulses, at edge N+2.
  - Latency from strobe to result is 2 cycles.
- Re-evaluation in UNLOCKED has 1-cycle latency. The state, attempt_done and timer reload all register at edge N+1.
- Unlock window: unlocked stays high for exactly UNLOCK_CYCLES cycles, then drops.
- Lockout: lockout stays high for exactly LOCKOUT_CYCLES cycles.
- In both cases, the first LOCKED cycle accepts a strobe.
- All outputs are registered and change on the clk rising edge. There are no combinational paths from inputs to outputs.

## Structure
- Shared package sentinel_pkg holds:
  - the state enum sentinel_state_t;
  - KEY_DEFAULT = 8'hB6;
  - the segment constants SEG_LOCKED = 8'hC7, SEG_VERIFIED = 8'hC1, SEG_OFF = 8'hFF, so the display driver and this block agree.
- Sub-module sentinel_timer: a loadable down-counter. Inputs are load, load_val, en; output is zero. One instance serves both the window and the lockout.
- The FSM and fail counter live in sentinel_auth_ctrl.

## Test plan
Bench parameters: MAX_FAILS=3, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16.
- Correct key: strobe key_in=0xB6 at edge N → unlocked=1 at N+2 for 8 cycles, attempt_ok=1, then state=LOCKED.
- Lockout entry: strobes with 0x00, 0x11, 0x22 → fail_count 1, 2, 3; lockout=1 two cycles after the third strobe.
  - A strobe of 0xB6 during lockout gives no attempt_done.
  - lockout falls after 16 cycles and fail_count returns to 0.
- Failure reset: 0x00 then 0xB6 → fail_count goes to 1, then to 0 with unlocked=1.
  - Follow with two bad keys: lockout must not trigger.
- Unlock re-evaluation: while unlocked, strobe 0xB6 at window cycle 6 → window extends 8 more cycles.
  - Strobe 0x5A → state=LOCKED next cycle, fail_count unchanged.
- Enable and reset: ena=0 mid-lockout for 20 cycles → state/timer frozen, lockout held; it resumes on ena=1.
  - ena=0 while unlocked → unlocked=0.
  - Assert rst_n low mid-window → all outputs 0 and state=LOCKED without a clock edge.
